// File: rtl/uc_engine_scheduler.sv
// Round-robin drain of the per-engine implied-unit-clause queues into the
// unit clause arbiter, one literal per cycle, plus solve-phase sequencing
// (idle, load, run, SAT-quiescent, UNSAT-halt).
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start           one-cycle pulse, begins a solve (IDLE/SAT/UNSAT -> LOAD)
//   load_done       memory unit-clause load finished (LOAD -> RUN)
//   eng_valid       per-engine queue non-empty
//   eng_lit         per-engine head literal, engine i at [i*LIT_W +: LIT_W]
//   eng_busy        per-engine still propagating
//   eng_pop         one-hot pop to the granted engine (combinational)
//   uca_valid/lit   single-entry output register towards the arbiter
//   uca_ready       arbiter accepts the literal this cycle
//   conflict        arbiter saw conflicting polarities
//   grant_idx       engine that produced uca_lit
//   state_o         current phase encoding
//   sat_done        quiescent without conflict
//   unsat_done      conflict observed
module uc_engine_scheduler #(
    parameter int unsigned NUM_ENGINE   = 4,
    parameter int unsigned LIT_IDX_MAX  = 127,
    parameter int unsigned LIT_W        = $clog2(LIT_IDX_MAX) + 1,
    parameter int unsigned QUIET_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          load_done,
    input  logic [NUM_ENGINE-1:0]         eng_valid,
    input  logic [NUM_ENGINE*LIT_W-1:0]   eng_lit,
    input  logic [NUM_ENGINE-1:0]         eng_busy,
    output logic [NUM_ENGINE-1:0]         eng_pop,
    output logic                          uca_valid,
    output logic [LIT_W-1:0]              uca_lit,
    input  logic                          uca_ready,
    input  logic                          conflict,
    output logic [$clog2(NUM_ENGINE)-1:0] grant_idx,
    output logic [2:0]                    state_o,
    output logic                          sat_done,
    output logic                          unsat_done
);

    localparam int unsigned IDX_W = $clog2(NUM_ENGINE);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned CNT_W = $clog2(QUIET_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_SAT   = 3'd3,
        S_UNSAT = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
    logic [CNT_W-1:0]   quiet_cnt, quiet_cnt_d;
    logic               uca_valid_d;
    logic [LIT_W-1:0]   uca_lit_d;
    logic [IDX_W-1:0]   grant_idx_d;

    logic [LIT_W-1:0]   lits [NUM_ENGINE];
    logic [PTR_W-1:0]   pos;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [LIT_W-1:0]   win_lit;
    logic [IDX_W-1:0]   win_next;
    logic               grant;
    logic               idle_c;

    // Unpack the flat literal bus into per-engine slots.
    always_comb begin
        for (int i = 0; i < NUM_ENGINE; i++) begin
            lits[i] = eng_lit[i*LIT_W +: LIT_W];
        end
    end

    // First valid engine scanning from rr_ptr with wrap-around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        pos       = '0;
        for (int k = 0; k < NUM_ENGINE; k++) begin
            pos = PTR_W'(rr_ptr) + PTR_W'(k);
            if (pos >= PTR_W'(NUM_ENGINE)) begin
                pos = pos - PTR_W'(NUM_ENGINE);
            end
            if (!win_found && eng_valid[pos[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = pos[IDX_W-1:0];
            end
        end
    end

    assign win_lit  = lits[win_idx];
    assign win_next = (win_idx == IDX_W'(NUM_ENGINE - 1)) ? '0 : win_idx + 1'b1;

    // A grant needs the output slot empty or draining this cycle.
    assign grant  = (state_q == S_RUN) && (!uca_valid || uca_ready) && win_found;
    assign idle_c = (eng_valid == '0) && (eng_busy == '0) && !uca_valid && !conflict;

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr;
        quiet_cnt_d = quiet_cnt;
        uca_valid_d = uca_valid;
        uca_lit_d   = uca_lit;
        grant_idx_d = grant_idx;
        eng_pop     = '0;

        case (state_q)
            S_IDLE, S_SAT, S_UNSAT: begin
                if (start) begin
                    state_d     = S_LOAD;
                    rr_ptr_d    = '0;
                    quiet_cnt_d = '0;
                    uca_valid_d = 1'b0;
                    uca_lit_d   = '0;
                    grant_idx_d = '0;
                end
            end

            S_LOAD: begin
                if (conflict) begin
                    state_d     = S_UNSAT;
                    uca_valid_d = 1'b0;
                end else if (load_done) begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (uca_valid && uca_ready) begin
                    uca_valid_d = 1'b0;
                end

                // Pop happens even on conflict so the engine side stays consistent;
                // zero literals are consumed but never presented.
                if (grant) begin
                    eng_pop[win_idx] = 1'b1;
                    rr_ptr_d         = win_next;
                    if (win_lit != '0 && !conflict) begin
                        uca_valid_d = 1'b1;
                        uca_lit_d   = win_lit;
                        grant_idx_d = win_idx;
                    end
                end

                if (idle_c) begin
                    if (quiet_cnt != CNT_W'(QUIET_CYCLES)) begin
                        quiet_cnt_d = quiet_cnt + 1'b1;
                    end
                    if (quiet_cnt == CNT_W'(QUIET_CYCLES - 1)) begin
                        state_d = S_SAT;
                    end
                end else begin
                    quiet_cnt_d = '0;
                end

                if (conflict) begin
                    state_d     = S_UNSAT;
                    uca_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            rr_ptr     <= '0;
            quiet_cnt  <= '0;
            uca_valid  <= 1'b0;
            uca_lit    <= '0;
            grant_idx  <= '0;
            sat_done   <= 1'b0;
            unsat_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr     <= rr_ptr_d;
            quiet_cnt  <= quiet_cnt_d;
            uca_valid  <= uca_valid_d;
            uca_lit    <= uca_lit_d;
            grant_idx  <= grant_idx_d;
            sat_done   <= (state_d == S_SAT);
            unsat_done <= (state_d == S_UNSAT);
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_uc_engine_scheduler.sv
// Bench for uc_engine_scheduler: engine queues modelled as SV queues, a
// round-robin reference model predicting pops and literals into a scoreboard,
// and directed phase/boundary scenarios.
module tb_uc_engine_scheduler;

    localparam int NE = 4;
    localparam int LW = 8;

    logic            clk;
    logic            rst;
    logic            start;
    logic            load_done;
    logic [NE-1:0]   eng_valid;
    logic [NE*LW-1:0] eng_lit;
    logic [NE-1:0]   eng_busy;
    logic [NE-1:0]   eng_pop;
    logic            uca_valid;
    logic [LW-1:0]   uca_lit;
    logic            uca_ready;
    logic            conflict;
    logic [1:0]      grant_idx;
    logic [2:0]      state_o;
    logic            sat_done;
    logic            unsat_done;

    uc_engine_scheduler #(
        .NUM_ENGINE  (NE),
        .LIT_IDX_MAX (127),
        .QUIET_CYCLES(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .load_done (load_done),
        .eng_valid (eng_valid),
        .eng_lit   (eng_lit),
        .eng_busy  (eng_busy),
        .eng_pop   (eng_pop),
        .uca_valid (uca_valid),
        .uca_lit   (uca_lit),
        .uca_ready (uca_ready),
        .conflict  (conflict),
        .grant_idx (grant_idx),
        .state_o   (state_o),
        .sat_done  (sat_done),
        .unsat_done(unsat_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int lit;
        int idx;
    } exp_t;

    int        q [NE][$];
    exp_t      exp_q [$];
    logic [NE-1:0] pend_pop;
    int        total_pops;
    bit        sb_en;
    int        m_rr;
    bit        m_full;
    int        checks;
    int        errors;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic int lit_s();
        return int'($signed(uca_lit));
    endfunction

    // Present queue heads to the DUT.
    task automatic refresh();
        for (int i = 0; i < NE; i++) begin
            eng_valid[i] = (q[i].size() > 0);
            eng_lit[i*LW +: LW] = (q[i].size() > 0) ? LW'(q[i][0]) : '0;
        end
    endtask

    // Advance one clock; engines pop on the edge the DUT granted.
    task automatic cycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NE; i++) begin
            if (pend_pop[i] && q[i].size() > 0) void'(q[i].pop_front());
        end
        refresh();
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        start     = 1'b0;
        load_done = 1'b0;
        conflict  = 1'b0;
        uca_ready = 1'b0;
        eng_busy  = '1;
        sb_en     = 1'b0;
        for (int i = 0; i < NE; i++) q[i].delete();
        exp_q.delete();
        m_rr   = 0;
        m_full = 1'b0;
        refresh();
        cycle();
        cycle();
        rst = 1'b1;
        #1;
    endtask

    task automatic go_run();
        start = 1'b1;
        cycle();
        start     = 1'b0;
        load_done = 1'b1;
        cycle();
        load_done = 1'b0;
    endtask

    // Scoreboard monitor and round-robin reference model.
    always @(negedge clk) begin
        int   w;
        bit   found;
        bit   can;
        exp_t e;
        pend_pop = eng_pop;
        if (rst) total_pops += $countones(eng_pop);
        if (rst && sb_en) begin
            chk("sb_valid", int'(uca_valid), int'(m_full));
            if (uca_valid && uca_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected", lit_s(), 9999);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_lit", lit_s(), e.lit);
                    chk("sb_idx", int'(grant_idx), e.idx);
                end
            end
            can   = !m_full || uca_ready;
            found = 1'b0;
            w     = 0;
            for (int k = 0; k < NE; k++) begin
                if (!found && q[(m_rr + k) % NE].size() > 0) begin
                    found = 1'b1;
                    w     = (m_rr + k) % NE;
                end
            end
            if (m_full && uca_ready) m_full = 1'b0;
            if (can && found) begin
                chk("sb_pop", int'(eng_pop), 1 << w);
                m_rr = (w + 1) % NE;
                if (q[w][0] != 0) begin
                    e.lit = q[w][0];
                    e.idx = w;
                    exp_q.push_back(e);
                    m_full = 1'b1;
                end
            end else begin
                chk("sb_nopop", int'(eng_pop), 0);
            end
        end
    end

    initial begin
        int pops0;
        checks     = 0;
        errors     = 0;
        total_pops = 0;
        pend_pop   = '0;
        eng_valid  = '0;
        eng_lit    = '0;

        // Reset state
        do_reset();
        chk("rst_state", int'(state_o), 0);
        chk("rst_valid", int'(uca_valid), 0);
        chk("rst_lit", int'(uca_lit), 0);
        chk("rst_idx", int'(grant_idx), 0);
        chk("rst_pop", int'(eng_pop), 0);
        chk("rst_sat", int'(sat_done), 0);
        chk("rst_unsat", int'(unsat_done), 0);

        // Fairness: engine i holds i+1, -(i+1)
        do_reset();
        for (int i = 0; i < NE; i++) begin
            q[i].push_back(i + 1);
            q[i].push_back(-(i + 1));
        end
        refresh();
        uca_ready = 1'b1;
        go_run();
        sb_en = 1'b1;
        pops0 = total_pops;
        chk("fair_state", int'(state_o), 2);
        chk("fair_first_pop", int'(eng_pop), 1);
        for (int k = 0; k < 2 * NE; k++) begin
            cycle();
            chk("fair_valid", int'(uca_valid), 1);
            chk("fair_lit", lit_s(), (k < NE) ? (k + 1) : -(k - NE + 1));
            chk("fair_idx", int'(grant_idx), k % NE);
        end
        cycle();
        chk("fair_drained", int'(uca_valid), 0);
        chk("fair_pops", total_pops - pops0, 2 * NE);

        // Backpressure: only engine 2 holds 5 then 6
        do_reset();
        q[2].push_back(5);
        q[2].push_back(6);
        refresh();
        go_run();
        sb_en = 1'b1;
        chk("bp_grant", int'(eng_pop), 4);
        for (int j = 1; j <= 4; j++) begin
            cycle();
            if (j == 4) begin
                uca_ready = 1'b1;
                #1;
            end
            chk("bp_valid", int'(uca_valid), 1);
            chk("bp_lit", lit_s(), 5);
            chk("bp_idx", int'(grant_idx), 2);
            chk("bp_pop", int'(eng_pop), (j == 4) ? 4 : 0);
        end
        cycle();
        chk("bp_next_lit", lit_s(), 6);
        chk("bp_next_pop", int'(eng_pop), 0);
        cycle();
        chk("bp_empty", int'(uca_valid), 0);

        // Wrap-around from pointer 3 with engines 3 and 0
        q[3].push_back(9);
        q[0].push_back(-3);
        refresh();
        #1;
        chk("wrap_pop3", int'(eng_pop), 8);
        cycle();
        chk("wrap_lit3", lit_s(), 9);
        chk("wrap_idx3", int'(grant_idx), 3);
        chk("wrap_pop0", int'(eng_pop), 1);
        cycle();
        chk("wrap_lit0", lit_s(), -3);
        chk("wrap_idx0", int'(grant_idx), 0);
        q[0].push_back(11);
        q[1].push_back(12);
        refresh();
        #1;
        chk("wrap_ptr1", int'(eng_pop), 2);
        cycle();
        chk("wrap_lit1", lit_s(), 12);
        cycle();
        chk("wrap_lit0b", lit_s(), 11);
        cycle();
        chk("wrap_empty", int'(uca_valid), 0);
        chk("sb_left", exp_q.size(), 0);
        sb_en = 1'b0;

        // Quiescence with a busy pulse on idle cycle 2
        do_reset();
        eng_busy = '0;
        uca_ready = 1'b1;
        q[0].push_back(1);
        refresh();
        go_run();
        cycle();
        chk("q_accept", int'(uca_valid), 1);
        cycle();
        chk("q_idle1", int'(uca_valid), 0);
        cycle();
        eng_busy = 4'b0010;
        cycle();
        eng_busy = '0;
        for (int j = 0; j < 4; j++) begin
            chk("q_not_yet", int'(sat_done), 0);
            chk("q_run", int'(state_o), 2);
            cycle();
        end
        chk("q_sat", int'(sat_done), 1);
        chk("q_state", int'(state_o), 3);
        cycle();
        chk("q_hold", int'(state_o), 3);
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("q_restart", int'(state_o), 1);
        chk("q_sat_clr", int'(sat_done), 0);

        // Conflict while engine 1 is granted -7
        do_reset();
        uca_ready = 1'b1;
        q[1].push_back(-7);
        refresh();
        go_run();
        conflict = 1'b1;
        #1;
        chk("c_pop", int'(eng_pop), 2);
        cycle();
        conflict = 1'b0;
        chk("c_state", int'(state_o), 4);
        chk("c_unsat", int'(unsat_done), 1);
        chk("c_valid", int'(uca_valid), 0);
        chk("c_lit_hidden", int'(lit_s() == -7), 0);
        chk("c_engine_popped", q[1].size(), 0);
        q[2].push_back(3);
        refresh();
        #1;
        chk("c_nopop", int'(eng_pop), 0);
        cycle();
        chk("c_hold", int'(state_o), 4);
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("c_restart", int'(state_o), 1);
        chk("c_unsat_clr", int'(unsat_done), 0);
        chk("c_load_nopop", int'(eng_pop), 0);
        load_done = 1'b1;
        conflict  = 1'b1;
        cycle();
        load_done = 1'b0;
        conflict  = 1'b0;
        chk("c_load_conflict", int'(state_o), 4);

        // Randomized traffic against the scoreboard
        do_reset();
        go_run();
        sb_en = 1'b1;
        for (int n = 0; n < 400; n++) begin
            cycle();
            uca_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                int e;
                e = int'($urandom_range(0, NE - 1));
                if (q[e].size() < 3) q[e].push_back(int'($urandom_range(0, 40)) - 20);
            end
            refresh();
        end
        uca_ready = 1'b1;
        for (int n = 0; n < 30; n++) cycle();
        chk("rand_drain", exp_q.size(), 0);
        chk("rand_engines_empty", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);
        sb_en = 1'b0;

        // Asynchronous reset mid-RUN with a live output
        do_reset();
        q[0].push_back(1);
        q[0].push_back(2);
        q[0].push_back(3);
        refresh();
        go_run();
        cycle();
        uca_ready = 1'b1;
        #1;
        chk("ar_pre_valid", int'(uca_valid), 1);
        chk("ar_pre_pop", int'(eng_pop), 1);
        rst = 1'b0;
        #1;
        chk("ar_valid", int'(uca_valid), 0);
        chk("ar_pop", int'(eng_pop), 0);
        chk("ar_state", int'(state_o), 0);
        chk("ar_sat", int'(sat_done), 0);
        chk("ar_unsat", int'(unsat_done), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
